// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, tracks the one outstanding memory read,
// and buffers responses in a 2-entry FIFO feeding the IF/ID valid/ready handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_data,
    input  logic        imem_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_err
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } entry_t;

    logic [31:0] pc;
    logic        inf_v;
    logic [31:0] inf_pc;
    logic        inf_mis;
    entry_t      fifo [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    entry_t      resp;
    entry_t      head;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occ;

    always_comb begin
        resp.pc   = inf_pc;
        resp.inst = inf_mis ? 32'h0 : imem_data;
        resp.err  = imem_err | inf_mis;

        if (count != 2'd0)
            head = fifo[rd_ptr];
        else if (inf_v)
            head = resp;
        else
            head = '0;

        if_valid = !redirect_valid && (count != 2'd0 || inf_v);
        pop      = if_valid && id_ready;
        // A bypassed response that decode takes this cycle never enters the FIFO.
        push     = !redirect_valid && inf_v && !(count == 2'd0 && pop);
        // pop implies something is present, so this difference never goes negative.
        occ      = {1'b0, count} + {2'b0, inf_v} - {2'b0, pop};
        issue    = !redirect_valid && (occ < 3'd2);
    end

    assign imem_addr = pc;
    assign imem_en   = issue;
    assign if_pc     = head.pc;
    assign if_inst   = head.inst;
    assign if_err    = head.err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            inf_v   <= 1'b0;
            inf_pc  <= 32'h0;
            inf_mis <= 1'b0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            inf_v  <= 1'b0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            inf_v <= issue;
            if (issue) begin
                inf_pc  <= pc;
                inf_mis <= (pc[1:0] != 2'b00);
                pc      <= pc + 32'd4;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop && count != 2'd0) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop && count != 2'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= resp;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory that returns its own address, and a model
// that predicts the delivered instruction stream from the last reset/redirect target.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] ERR_ADDR = 32'hBFC0_0018;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;
    logic        imem_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_err;

    int          vectors = 0;
    int          errs = 0;
    logic [31:0] exp_pc;
    int          age;
    logic        prev_rv;
    logic [31:0] prev_rpc;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .imem_err(imem_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_err(if_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory: each word holds its own address; one address faults.
    always @(posedge clk) begin
        imem_data <= imem_addr;
        imem_err  <= (imem_addr == ERR_ADDR);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then predict the next edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic mis;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        #1;
        if (prev_rv) chk("redir_addr", imem_addr, prev_rpc);
        if (prev_rv && !rv) chk("redir_issue", {31'b0, imem_en}, 32'd1);
        if (rv) chk("redir_valid", {31'b0, if_valid}, 32'd0);
        else if (age >= 1) chk("steady_valid", {31'b0, if_valid}, 32'd1);
        if (if_valid) begin
            mis = (exp_pc[1:0] != 2'b00);
            chk("head_pc", if_pc, exp_pc);
            chk("head_inst", if_inst, mis ? 32'h0 : exp_pc);
            chk("head_err", {31'b0, if_err}, {31'b0, mis || exp_pc == ERR_ADDR});
        end
        prev_rv  = rv;
        prev_rpc = rpc;
        if (rv) begin
            exp_pc = rpc;
            age    = 0;
        end else begin
            age++;
            if (if_valid && rdy) exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        redirect_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_err", {31'b0, if_err}, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_en", {31'b0, imem_en}, 32'd1);
        exp_pc  = RESET_PC;
        age     = 1;
        prev_rv = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;

        apply_reset();
        repeat (6) step(1'b0, 32'h0, 1'b1);
        // Stall with the faulting word at the head; issue stops once two are held.
        step(1'b0, 32'h0, 1'b0);
        chk("stall_en1", {31'b0, imem_en}, 32'd1);
        repeat (4) begin
            step(1'b0, 32'h0, 1'b0);
            chk("stall_en0", {31'b0, imem_en}, 32'd0);
        end
        repeat (6) begin
            step(1'b0, 32'h0, 1'b1);
            chk("drain_en", {31'b0, imem_en}, 32'd1);
        end
        repeat (3) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0040_0100, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0040_0102, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        apply_reset();
        repeat (4) step(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else begin
                rpc = $urandom;
                if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
                if ($urandom_range(0, 9) == 0) rpc = ERR_ADDR - 32'd8;
                step(($urandom_range(0, 19) == 0), rpc, ($urandom_range(0, 9) < 7));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
